// File: rtl/deserializer.sv
// Bit-serial to byte deserializer with SYNC_WORD framing (HUNT/VERIFY/LOCKED).
// Optional DESER_SYNC_DROP_EN: suppress sync bytes seen while locked.
module deserializer #(
  parameter logic [7:0]  SYNC_WORD = 8'hA5,
  parameter int unsigned LOCK_CNT  = 2
) (
  input  logic       t_clk,
  input  logic       rst,
  input  logic       data_in,
  input  logic       realign,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       locked
);

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [3:0] LOCK_N = 4'(LOCK_CNT);

`ifdef DESER_SYNC_DROP_EN
  localparam logic DROP_SYNC = 1'b1;
`else
  localparam logic DROP_SYNC = 1'b0;
`endif

  logic [1:0] state_q, state_d;
  logic [7:0] shift_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] match_q, match_d;
  logic [7:0] dout_q, dout_d;
  logic       valid_q, valid_d;
  logic       locked_q;

  logic [7:0] word;
  logic       is_sync;
  logic       boundary;

  assign word     = {shift_q[6:0], data_in};
  assign is_sync  = (word == SYNC_WORD);
  assign boundary = (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q + 3'd1;
    match_d   = match_q;
    dout_d    = dout_q;
    valid_d   = 1'b0;
    if (realign) begin
      state_d = HUNT;
      match_d = 4'd0;
    end else begin
      case (state_q)
        HUNT: begin
          bit_cnt_d = bit_cnt_q;
          if (is_sync) begin
            state_d   = VERIFY;
            bit_cnt_d = 3'd0;
            match_d   = 4'd0;
          end
        end
        VERIFY: begin
          if (boundary) begin
            if (is_sync) begin
              match_d = match_q + 4'd1;
              if (match_q + 4'd1 == LOCK_N)
                state_d = LOCKED;
            end else begin
              state_d = HUNT;
              match_d = 4'd0;
            end
          end
        end
        LOCKED: begin
          // sync bytes seen in lock are payload unless dropping is enabled
          if (boundary && !(DROP_SYNC && is_sync)) begin
            dout_d  = word;
            valid_d = 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge t_clk or posedge rst) begin
    if (rst) begin
      state_q   <= HUNT;
      shift_q   <= 8'h00;
      bit_cnt_q <= 3'd0;
      match_q   <= 4'd0;
      dout_q    <= 8'h00;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= word;
      bit_cnt_q <= bit_cnt_d;
      match_q   <= match_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      locked_q  <= (state_d == LOCKED);
    end
  end

  assign data_out   = dout_q;
  assign data_valid = valid_q;
  assign locked     = locked_q;

endmodule
